// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator producing vs/hs/de, pixel coordinates and frame_start
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COORD_W  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               vs_out,
  output logic               hs_out,
  output logic               de_out,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] H_HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] V_VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               de_d;
  logic               hs_d;
  logic               vs_d;
  logic               fs_d;

  // Decode the current raster position; registered below so outputs lag the counters by one clock
  always_comb begin
    de_d = 1'b0;
    hs_d = 1'b0;
    vs_d = 1'b0;
    fs_d = 1'b0;
    de_d = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_d = (h_cnt >= H_HS_BEG) && (h_cnt < H_HS_END);
    vs_d = (v_cnt >= V_VS_BEG) && (v_cnt < V_VS_END);
    fs_d = (h_cnt == '0) && (v_cnt == '0);
  end

  // Raster position counters; frozen while enable is low, always restart at (0,0) after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (enable) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + ONE;
        end
      end else begin
        h_cnt <= h_cnt + ONE;
      end
    end
  end

  // Output register; holds every output (including a pending frame_start) during a stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_out      <= ~HS_POL;
      vs_out      <= ~VS_POL;
      de_out      <= 1'b0;
      frame_start <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
    end else if (enable) begin
      hs_out      <= hs_d ? HS_POL : ~HS_POL;
      vs_out      <= vs_d ? VS_POL : ~VS_POL;
      de_out      <= de_d;
      frame_start <= fs_d;
      x_out       <= de_d ? h_cnt : '0;
      y_out       <= de_d ? v_cnt : '0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on a small raster, both sync polarities
module tb_video_timing_gen;

  localparam int CW      = 4;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int H_TOTAL = HA + HF + HS + HB;
  localparam int V_TOTAL = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;

  logic          vs_a, hs_a, de_a, fs_a;
  logic [CW-1:0] x_a, y_a;
  logic          vs_b, hs_b, de_b, fs_b;
  logic [CW-1:0] x_b, y_b;

  int checks = 0;
  int errors = 0;
  int mh = 0;
  int mv = 0;
  logic [23:0] sb_q[$];
  logic [23:0] last_exp;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .COORD_W(CW)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .vs_out(vs_a), .hs_out(hs_a), .de_out(de_a),
    .x_out(x_a), .y_out(y_a), .frame_start(fs_a)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .COORD_W(CW)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .vs_out(vs_b), .hs_out(hs_b), .de_out(de_b),
    .x_out(x_b), .y_out(y_b), .frame_start(fs_b)
  );

  initial begin
    assert ((H_TOTAL - 1) < (1 << CW) && (V_TOTAL - 1) < (1 << CW))
      else $error("FAIL param_range H_TOTAL=%0d V_TOTAL=%0d COORD_W=%0d", H_TOTAL, V_TOTAL, CW);
  end

  // Expected {vs,hs,de,fs,x,y} for a raster position, from the small-config timing table
  function automatic logic [11:0] expect_pos(input int h, input int v, input bit hp, input bit vp);
    logic de, hsy, vsy, fs;
    logic [3:0] x, y;
    de  = (h <= 3) && (v <= 2);
    hsy = (h == 5) || (h == 6);
    vsy = (v == 4);
    fs  = (h == 0) && (v == 0);
    x   = de ? 4'(h) : 4'd0;
    y   = de ? 4'(v) : 4'd0;
    return {(hp ? 1'b1 : 1'b0) == 1'b1 ? 1'b0 : 1'b0, 11'd0} |
           {(vp ? vsy : ~vsy), (hp ? hsy : ~hsy), de, fs, x, y};
  endfunction

  function automatic logic [23:0] expect_reset();
    return {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
  endfunction

  function automatic logic [23:0] observed();
    return {vs_a, hs_a, de_a, fs_a, x_a, y_a, vs_b, hs_b, de_b, fs_b, x_b, y_b};
  endfunction

  task automatic pop_compare(input string name);
    logic [23:0] e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty, got %h", name, observed());
    end else begin
      e = sb_q.pop_front();
      if (observed() !== e) begin
        errors++;
        $display("FAIL %s got %h expected %h (model h=%0d v=%0d)", name, observed(), e, mh, mv);
      end
    end
  endtask

  // One clock: drive enable at the falling edge, predict, then sample at the next falling edge
  task automatic step(input logic en, input string name);
    enable = en;
    if (en) begin
      last_exp = {expect_pos(mh, mv, 1'b1, 1'b1), expect_pos(mh, mv, 1'b0, 1'b0)};
      mh++;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv++;
        if (mv == V_TOTAL) mv = 0;
      end
    end
    sb_q.push_back(last_exp);
    @(posedge clk);
    @(negedge clk);
    pop_compare(name);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    mh = 0;
    mv = 0;
    last_exp = expect_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(expect_reset());
      @(posedge clk);
      @(negedge clk);
      pop_compare("reset_hold");
    end
    reset = 1'b1;
    step(1'b1, "reset_release");
    checks++;
    if ({de_a, fs_a, x_a, y_a} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL first_pixel got de=%b fs=%b x=%0d y=%0d expected de=1 fs=1 x=0 y=0", de_a, fs_a, x_a, y_a);
    end
  endtask

  task automatic test_line();
    int de_cnt;
    logic [7:0] hs_mask;
    de_cnt = int'(de_a);
    hs_mask = 8'(hs_a);
    for (int i = 1; i < H_TOTAL; i++) begin
      step(1'b1, "line");
      de_cnt += int'(de_a);
      hs_mask[i] = hs_a;
    end
    checks++;
    if (de_cnt != 4) begin
      errors++;
      $display("FAIL line_de_count got %0d expected 4", de_cnt);
    end
    checks++;
    if (hs_mask !== 8'b0110_0000) begin
      errors++;
      $display("FAIL line_hs_position got %b expected 01100000", hs_mask);
    end
  endtask

  task automatic test_frame();
    int de_cnt, vs_cnt, fs_cnt;
    de_cnt = 0;
    vs_cnt = 0;
    fs_cnt = 0;
    for (int i = 0; i < (V_TOTAL - 1) * H_TOTAL; i++) begin
      step(1'b1, "frame");
      de_cnt += int'(de_a);
      vs_cnt += int'(vs_a);
      fs_cnt += int'(fs_a);
    end
    checks++;
    if (de_cnt != 8 || vs_cnt != 8 || fs_cnt != 0) begin
      errors++;
      $display("FAIL frame_counts got de=%0d vs=%0d fs=%0d expected de=8 vs=8 fs=0", de_cnt, vs_cnt, fs_cnt);
    end
    step(1'b1, "frame_wrap");
    checks++;
    if (fs_a !== 1'b1) begin
      errors++;
      $display("FAIL frame_period fs=%b expected 1 after 48 clk", fs_a);
    end
  endtask

  task automatic test_stall();
    int clocks;
    step(1'b0, "stall_on_fs");
    checks++;
    if (fs_a !== 1'b1) begin
      errors++;
      $display("FAIL stall_fs_held got %b expected 1", fs_a);
    end
    clocks = 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, "stall_lead");
      clocks++;
    end
    checks++;
    if ({de_a, x_a, y_a} !== {1'b1, 4'd2, 4'd1}) begin
      errors++;
      $display("FAIL stall_position got de=%b x=%0d y=%0d expected de=1 x=2 y=1", de_a, x_a, y_a);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, "stall_hold");
      clocks++;
    end
    step(1'b1, "stall_resume");
    clocks++;
    checks++;
    if (x_a !== 4'd3) begin
      errors++;
      $display("FAIL stall_resume_x got %0d expected 3", x_a);
    end
    for (int i = 0; i < 100 && fs_a !== 1'b1; i++) begin
      step(1'b1, "stall_tail");
      clocks++;
    end
    checks++;
    if (fs_a !== 1'b1 || clocks != 54) begin
      errors++;
      $display("FAIL stall_frame_period got %0d clk fs=%b expected 54 clk (48 + 5 stall + 1 stall on fs)", clocks, fs_a);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 17; i++) step(1'b1, "mid_lead");
    checks++;
    if ({x_a, y_a} !== {4'd1, 4'd2}) begin
      errors++;
      $display("FAIL mid_position got x=%0d y=%0d expected x=1 y=2", x_a, y_a);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (observed() !== expect_reset()) begin
      errors++;
      $display("FAIL mid_reset_async got %h expected %h", observed(), expect_reset());
    end
    mh = 0;
    mv = 0;
    last_exp = expect_reset();
    @(negedge clk);
    sb_q.push_back(expect_reset());
    pop_compare("mid_reset_hold");
    reset = 1'b1;
    step(1'b1, "mid_restart");
    checks++;
    if ({fs_a, de_a, x_a, y_a} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL mid_restart got fs=%b de=%b x=%0d y=%0d expected fs=1 de=1 x=0 y=0", fs_a, de_a, x_a, y_a);
    end
  endtask

  task automatic test_polarity();
    int good;
    good = 0;
    for (int i = 0; i < H_TOTAL * V_TOTAL; i++) begin
      step(1'b1, "polarity");
      if (hs_b === ~hs_a && vs_b === ~vs_a && {de_b, fs_b, x_b, y_b} === {de_a, fs_a, x_a, y_a})
        good++;
    end
    checks++;
    if (good != H_TOTAL * V_TOTAL) begin
      errors++;
      $display("FAIL polarity_relation got %0d matching clk expected %0d", good, H_TOTAL * V_TOTAL);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_stall();
    test_reset_mid();
    test_polarity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
